// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and the
// round-robin index wrap used by the transmit arbiter and the future rx demux.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

  // Advance an index by one, wrapping from n-1 back to 0 without relying on
  // power-of-two overflow.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    int unsigned res;
    if (idx >= n - 1) begin
      res = 0;
    end else begin
      res = idx + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick: first set request at or above ptr,
// wrapping modulo N_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 32'(ptr);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!valid && req[IDX_W'(pos)]) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
      pos = next_idx(pos, N_REQ);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// holding off new grants while the receiver has a frame in progress.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned START_TO   = 16,
  parameter  int unsigned GAP_CYCLES = 0,
  localparam int unsigned OWNER_W    = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             req_lock,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic                         rx_int,
  input  logic                         tx_busy,
  output logic [N_REQ-1:0]             gnt,
  output logic                         tx_start,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic [OWNER_W-1:0]           owner,
  output logic                         arb_busy,
  output logic                         err_timeout
);

  localparam int unsigned CNT_MAX  = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned TO_LAST  = START_TO - 1;
  localparam int unsigned TO_WARN  = START_TO - 2;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_e             state_q, state_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic                   lock_q, lock_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic                   tx_start_q, tx_start_d;
  logic                   err_q, err_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;

  logic                   win_valid;
  logic [OWNER_W-1:0]     win_idx;
  logic                   eligible;
  logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*UART_BYTE_W +: UART_BYTE_W];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // The transmitter must be idle too, so a reset mid-transfer cannot re-launch
  // on top of a byte still shifting out.
  assign eligible = win_valid && !rx_int && !tx_busy;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    gnt_d      = '0;
    tx_start_d = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          owner_d    = win_idx;
          data_d     = req_bytes[win_idx];
          lock_d     = req_lock[win_idx];
          gnt_d      = N_REQ'(1) << win_idx;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        ptr_d   = lock_q ? owner_q : OWNER_W'(next_idx(32'(owner_q), N_REQ));
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // err is raised one count early so the registered pulse lands exactly
        // START_TO cycles after tx_start, in the last WAIT_BUSY cycle.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TO_LAST)) begin
          state_d = ST_IDLE;
        end else if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(TO_WARN)) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = data_q;
  assign owner       = owner_q;
  assign err_timeout = err_q;
  assign arb_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_lock = '0;
  logic [8*N-1:0] req_data = '0;
  logic           rx_int = 1'b0;
  logic           tx_busy = 1'b0;
  logic [N-1:0]   gnt;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [W-1:0]   owner;
  logic           arb_busy;
  logic           err_timeout;

  uart_tx_arbiter #(
    .N_REQ      (N),
    .START_TO   (TO),
    .GAP_CYCLES (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_lock    (req_lock),
    .req_data    (req_data),
    .rx_int      (rx_int),
    .tx_busy     (tx_busy),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .owner       (owner),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: tracks the transfer in progress by timestamps and picks
  // the winner by scanning requesters from the rotating pointer.
  localparam int M_FREE = 0, M_LAUNCH = 1, M_AWAIT = 2, M_SEND = 3, M_TIMED = 4;
  int         m_mode = M_FREE;
  int         m_ptr = 0;
  int         m_start = 0;
  int         m_win = 0;
  bit         m_lock = 1'b0;
  bit         e_start = 1'b0;
  bit         e_err = 1'b0;
  bit         e_busy = 1'b0;
  logic [N-1:0] e_gnt = '0;
  int         e_owner = 0;
  logic [7:0] e_data = '0;

  always @(posedge clk) begin
    cyc++;
    e_start = 1'b0;
    e_gnt   = '0;
    e_err   = 1'b0;
    if (rst) begin
      m_mode  = M_FREE;
      m_ptr   = 0;
      m_lock  = 1'b0;
      e_owner = 0;
      e_data  = '0;
    end else begin
      case (m_mode)
        M_FREE: begin
          if (req != '0 && !rx_int && !tx_busy) begin
            m_win = -1;
            for (int k = 0; k < N; k++) begin
              if (m_win < 0 && req[W'((m_ptr + k) % N)]) m_win = (m_ptr + k) % N;
            end
            e_owner = m_win;
            e_data  = req_data[8*m_win +: 8];
            m_lock  = req_lock[W'(m_win)];
            e_start = 1'b1;
            e_gnt   = 4'b0001 << m_win;
            m_start = cyc;
            m_mode  = M_LAUNCH;
          end
        end
        M_LAUNCH: begin
          m_ptr  = m_lock ? e_owner : (e_owner + 1) % N;
          m_mode = M_AWAIT;
        end
        M_AWAIT: begin
          if (tx_busy) m_mode = M_SEND;
          else if (cyc - m_start == TO) begin
            e_err  = 1'b1;
            m_mode = M_TIMED;
          end
        end
        M_SEND:  if (!tx_busy) m_mode = M_FREE;
        default: m_mode = M_FREE;
      endcase
    end
    e_busy = (m_mode != M_FREE);
  end

  // Per-cycle compare, event logging and the transmitter model.
  int         xd = 2;
  int         xl = 20;
  bit         xmt_en = 1'b1;
  int         dly = 0;
  int         hold = 0;
  bit         prev_arb = 1'b0;
  int         last_fall = -1;
  int         last_idle = -1;
  int         rises = 0;
  int         st_cyc[$];
  int         st_own[$];
  logic [N-1:0] st_gnt[$];
  logic [7:0] st_data[$];
  int         err_cyc[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tx_start", 32'(tx_start), 32'(e_start));
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("err_timeout", 32'(err_timeout), 32'(e_err));
      chk("arb_busy", 32'(arb_busy), 32'(e_busy));
      chk("owner", 32'(owner), e_owner);
      chk("tx_data", 32'(tx_data), 32'(e_data));
    end
    if (tx_start) begin
      st_cyc.push_back(cyc);
      st_own.push_back(int'(owner));
      st_gnt.push_back(gnt);
      st_data.push_back(tx_data);
    end
    if (err_timeout) err_cyc.push_back(cyc);
    if (prev_arb && !arb_busy) last_idle = cyc;
    prev_arb = arb_busy;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        tx_busy = 1'b1;
        hold    = xl;
        rises++;
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) begin
        tx_busy   = 1'b0;
        last_fall = cyc;
      end
    end
    if (tx_start && xmt_en) dly = xd;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic log_clear();
    st_cyc.delete();
    st_own.delete();
    st_gnt.delete();
    st_data.delete();
    err_cyc.delete();
  endtask

  task automatic wait_starts(input int n, input int lim, input string nm);
    int c = 0;
    while (st_cyc.size() < n && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(st_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_quiet(input int lim, input string nm);
    int c = 0;
    int q = 0;
    while (q < 2 && c < lim) begin
      @(negedge clk);
      c++;
      if (!arb_busy && !tx_busy && dly == 0 && hold == 0) q++;
      else q = 0;
    end
    chk(nm, 32'(q >= 2), 32'd1);
  endtask

  int exp_rr[5]   = '{0, 1, 2, 3, 0};
  int exp_lock[4] = '{0, 0, 0, 2};
  int rises0;
  int mark;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // Single requester
    log_clear();
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    mark = cyc;
    wait_starts(1, 20, "t1_grant_seen");
    req = '0;
    wait_quiet(100, "t1_quiet");
    if (st_cyc.size() >= 1) begin
      chk("t1_latency", st_cyc[0] - mark, 1);
      chk("t1_data", 32'(st_data[0]), 32'hA5);
      chk("t1_gnt", 32'(st_gnt[0]), 32'b0010);
      chk("t1_owner", st_own[0], 1);
    end
    chk("t1_idle_after_fall", last_idle - last_fall, 1);

    // Round-robin with all requesters held
    do_reset();
    log_clear();
    rises0 = rises;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    req = 4'b1111;
    wait_starts(5, 200, "t2_grants_seen");
    req = '0;
    wait_quiet(100, "t2_quiet");
    for (int i = 0; i < 5; i++) begin
      if (st_cyc.size() > i) begin
        chk("t2_order", st_own[i], exp_rr[i]);
        chk("t2_data", 32'(st_data[i]), 32'(8'h10 + exp_rr[i]));
      end
    end
    chk("t2_start_per_busy", rises - rises0, st_cyc.size());

    // Burst lock
    do_reset();
    log_clear();
    req_data[7:0]   = 8'hC0;
    req_data[23:16] = 8'hC2;
    req_lock = 4'b0001;
    req = 4'b0101;
    wait_starts(2, 100, "t3_first_two");
    req_lock = '0;
    wait_starts(4, 150, "t3_all_four");
    req = '0;
    wait_quiet(100, "t3_quiet");
    for (int i = 0; i < 4; i++) begin
      if (st_cyc.size() > i) chk("t3_lock_order", st_own[i], exp_lock[i]);
    end

    // Receive hold-off, rx_int rising together with the request
    do_reset();
    log_clear();
    req_data[31:24] = 8'h3C;
    rx_int = 1'b1;
    req = 4'b1000;
    repeat (100) @(negedge clk);
    chk("t4_held_off", st_cyc.size(), 0);
    rx_int = 1'b0;
    mark = cyc;
    wait_starts(1, 20, "t4_grant_seen");
    if (st_cyc.size() >= 1) chk("t4_release_latency", st_cyc[0] - mark, 1);
    for (int i = 0; i < 10 && !tx_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rx_int = 1'b1;
    req = '0;
    wait_quiet(100, "t4_completes_under_rx");
    chk("t4_idle_after_fall", last_idle - last_fall, 1);
    rx_int = 1'b0;

    // Start timeout: transmitter never answers
    xmt_en = 1'b0;
    do_reset();
    log_clear();
    req_data[7:0]  = 8'h50;
    req_data[15:8] = 8'h51;
    req = 4'b0011;
    wait_starts(1, 20, "t5_first_grant");
    req = 4'b0010;
    wait_starts(2, 60, "t5_second_grant");
    req = '0;
    wait_quiet(100, "t5_quiet");
    chk("t5_err_count", err_cyc.size(), 2);
    if (err_cyc.size() >= 1 && st_cyc.size() >= 2) begin
      chk("t5_err_delay", err_cyc[0] - st_cyc[0], TO);
      chk("t5_next_start", st_cyc[1] - err_cyc[0], 2);
      chk("t5_next_owner", st_own[1], 1);
    end
    xmt_en = 1'b1;

    // Reset during WAIT_DONE with the transmitter still busy
    xl = 40;
    do_reset();
    log_clear();
    req_data[23:16] = 8'h66;
    req = 4'b0100;
    wait_starts(1, 20, "t6_grant_seen");
    req = '0;
    for (int i = 0; i < 10 && !tx_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    req_data[7:0] = 8'h77;
    req = 4'b0001;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t6_rst_owner", 32'(owner), 32'd0);
    chk("t6_rst_arb_busy", 32'(arb_busy), 32'd0);
    rst = 1'b0;
    wait_starts(2, 80, "t6_regrant_seen");
    req = '0;
    if (st_cyc.size() >= 2) begin
      chk("t6_start_after_fall", st_cyc[1] - last_fall, 1);
      chk("t6_owner", st_own[1], 0);
      chk("t6_data", 32'(st_data[1]), 32'h77);
    end
    wait_quiet(200, "t6_quiet");
    xl = 20;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
